// File: rtl/rv_ctrl_pkg.sv
// ============================================================================
// Module      : rv_ctrl_pkg
// Description : Shared types and encodings for the RV32I multi-cycle control FSM.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OPIMM   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_cls_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_SYS     = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rv_opcode_decode.sv
// ============================================================================
// Module      : rv_opcode_decode
// Description : Classifies the latched instruction and flags halting encodings.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  cls,
    output logic        halt_req,
    output logic [1:0]  halt_cause
);

    instr_cls_e cls_e;

    always_comb begin
        cls_e = CLS_ILLEGAL;
        case (instr[6:0])
            OPC_LUI:    cls_e = CLS_LUI;
            OPC_AUIPC:  cls_e = CLS_AUIPC;
            OPC_JAL:    cls_e = CLS_JAL;
            OPC_JALR:   cls_e = CLS_JALR;
            OPC_BRANCH: cls_e = CLS_BRANCH;
            OPC_LOAD:   cls_e = CLS_LOAD;
            OPC_STORE:  cls_e = CLS_STORE;
            OPC_OPIMM:  cls_e = CLS_OPIMM;
            OPC_OP:     cls_e = CLS_OP;
            default:    cls_e = CLS_ILLEGAL;
        endcase
    end

    // Only the two exact system encodings are a clean stop; other SYSTEM words are illegal.
    always_comb begin
        halt_req   = 1'b0;
        halt_cause = HALT_NONE;
        if (instr == INSTR_ECALL || instr == INSTR_EBREAK) begin
            halt_req   = 1'b1;
            halt_cause = HALT_SYS;
        end else if (cls_e == CLS_ILLEGAL) begin
            halt_req   = 1'b1;
            halt_cause = HALT_ILLEGAL;
        end
    end

    assign cls = cls_e;

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_ctrl.sv
// ============================================================================
// Module      : rv_multicycle_ctrl
// Description : Multi-cycle RV32I control FSM with retire counter and halt logic.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             rf_we,
    output logic [4:0]       rf_w,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instret
);

    localparam bit TO_EN = (MEM_TIMEOUT > 0);

    state_e           state_q, state_d;
    logic [1:0]       halt_cause_q, halt_cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [31:0]      to_cnt_q, to_cnt_d;

    logic [3:0]  dec_cls;
    logic        dec_halt;
    logic [1:0]  dec_cause;
    instr_cls_e  cls;

    logic ir_we_c, pc_we_c, mem_req_c, mem_we_c, rf_we_c;
    logic retire;
    logic wait_cyc;
    logic timeout_hit;

    rv_opcode_decode u_decode (
        .instr      (instr),
        .cls        (dec_cls),
        .halt_req   (dec_halt),
        .halt_cause (dec_cause)
    );

    assign cls  = instr_cls_e'(dec_cls);
    assign rf_w = instr[11:7];

    // The wait that would bring the counter to the limit is the timeout cycle itself.
    assign wait_cyc    = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
    assign timeout_hit = TO_EN && wait_cyc && (to_cnt_q == 32'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        rf_we_c      = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        addr_src     = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        wb_sel       = WB_SEL_ALU;
        retire       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (timeout_hit) begin
                    state_d      = ST_HALT;
                    halt_cause_d = HALT_TIMEOUT;
                end else begin
                    mem_req_c = 1'b1;
                    if (mem_ready) begin
                        ir_we_c = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    state_d      = ST_HALT;
                    halt_cause_d = dec_cause;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JALR: alu_src_b = 1'b1;
                    CLS_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
                if (cls == CLS_BRANCH) begin
                    pc_we_c = 1'b1;
                    pc_src  = br_taken ? PC_SRC_TARGET : PC_SRC_PLUS4;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (timeout_hit) begin
                    state_d      = ST_HALT;
                    halt_cause_d = HALT_TIMEOUT;
                end else begin
                    mem_req_c = 1'b1;
                    addr_src  = 1'b1;
                    mem_we_c  = (cls == CLS_STORE);
                    if (mem_ready) begin
                        if (cls == CLS_STORE) begin
                            pc_we_c = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
            end
            ST_WB: begin
                rf_we_c = (rf_w != 5'd0);
                pc_we_c = 1'b1;
                case (cls)
                    CLS_JAL: begin
                        pc_src = PC_SRC_TARGET;
                        wb_sel = WB_SEL_PC4;
                    end
                    CLS_JALR: begin
                        pc_src = PC_SRC_JALR;
                        wb_sel = WB_SEL_PC4;
                    end
                    CLS_LOAD: wb_sel = WB_SEL_LOAD;
                    CLS_LUI:  wb_sel = WB_SEL_IMM;
                    default:  wb_sel = WB_SEL_ALU;
                endcase
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        to_cnt_d = '0;
        if (TO_EN && wait_cyc && state_d == state_q) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
    end

    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            halt_cause_q <= HALT_NONE;
            instret_q    <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            instret_q    <= instret_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    // Strobes are forced low for as long as reset is held, even mid-access.
    assign ir_we   = ir_we_c   & ~rst;
    assign pc_we   = pc_we_c   & ~rst;
    assign mem_req = mem_req_c & ~rst;
    assign mem_we  = mem_we_c  & ~rst;
    assign rf_we   = rf_we_c   & ~rst;

    assign halted     = (state_q == ST_HALT);
    assign halt_cause = halt_cause_q;
    assign instret    = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_rv_multicycle_ctrl
// Description : Directed self-checking bench for rv_multicycle_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv_multicycle_ctrl;

    localparam logic [31:0] I_ADDI  = 32'h0070_0293;  // addi x5,x0,7
    localparam logic [31:0] I_LW    = 32'h0002_A303;  // lw   x6,0(x5)
    localparam logic [31:0] I_BEQ   = 32'h0000_0463;  // beq  x0,x0,+8
    localparam logic [31:0] I_ADD0  = 32'h0020_8033;  // add  x0,x1,x2
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;  // jal  x1,+16
    localparam logic [31:0] I_SW    = 32'h0050_2023;  // sw   x5,0(x0)
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;

    logic        ir_we, pc_we, mem_req, mem_we, addr_src, alu_src_a, alu_src_b;
    logic        rf_we, halted;
    logic [1:0]  pc_src, wb_sel, halt_cause;
    logic [4:0]  rf_w;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    rv_multicycle_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .br_taken   (br_taken),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_src   (addr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .rf_we      (rf_we),
        .rf_w       (rf_w),
        .wb_sel     (wb_sel),
        .halted     (halted),
        .halt_cause (halt_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle with the given mem_ready.
    task automatic next(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    // Release an asserted reset so that the following half-cycle is cycle 1.
    task automatic release_rst(input logic rdy);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        instr = I_ADDI;
        @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_ir_we", 32'(ir_we), 0);
        chk("rst_instret", instret, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_cause", 32'(halt_cause), 0);

        // ADDI, zero-wait: four cycles
        release_rst(1'b1);
        chk("addi_c1_ir_we", 32'(ir_we), 1);
        chk("addi_c1_mem_req", 32'(mem_req), 1);
        chk("addi_c1_addr_src", 32'(addr_src), 0);
        next(1'b1);
        chk("addi_c2_ir_we", 32'(ir_we), 0);
        next(1'b1);
        chk("addi_c3_alu_a", 32'(alu_src_a), 0);
        chk("addi_c3_alu_b", 32'(alu_src_b), 1);
        next(1'b1);
        chk("addi_c4_rf_we", 32'(rf_we), 1);
        chk("addi_c4_rf_w", 32'(rf_w), 5);
        chk("addi_c4_wb_sel", 32'(wb_sel), 0);
        chk("addi_c4_pc_we", 32'(pc_we), 1);
        chk("addi_c4_pc_src", 32'(pc_src), 0);
        next(1'b1);
        chk("addi_instret", instret, 1);

        // LW with three wait cycles in MEM
        instr = I_LW;
        next(1'b1);
        next(1'b1);
        chk("lw_c3_alu_b", 32'(alu_src_b), 1);
        next(1'b0);
        chk("lw_c4_mem_req", 32'(mem_req), 1);
        chk("lw_c4_addr_src", 32'(addr_src), 1);
        chk("lw_c4_mem_we", 32'(mem_we), 0);
        next(1'b0);
        next(1'b0);
        chk("lw_c6_mem_req", 32'(mem_req), 1);
        chk("lw_c6_halted", 32'(halted), 0);
        next(1'b1);
        chk("lw_c7_rf_we", 32'(rf_we), 0);
        chk("lw_c7_instret", instret, 1);
        next(1'b1);
        chk("lw_c8_rf_we", 32'(rf_we), 1);
        chk("lw_c8_wb_sel", 32'(wb_sel), 1);
        chk("lw_c8_rf_w", 32'(rf_w), 6);
        next(1'b1);
        chk("lw_instret", instret, 2);

        // BEQ taken, then BEQ not taken
        instr = I_BEQ;
        br_taken = 1'b1;
        next(1'b1);
        next(1'b1);
        chk("beq1_c3_pc_we", 32'(pc_we), 1);
        chk("beq1_c3_pc_src", 32'(pc_src), 1);
        chk("beq1_c3_rf_we", 32'(rf_we), 0);
        next(1'b1);
        chk("beq1_instret", instret, 3);
        chk("beq1_next_pc_we", 32'(pc_we), 0);
        br_taken = 1'b0;
        next(1'b1);
        next(1'b1);
        chk("beq2_c3_pc_we", 32'(pc_we), 1);
        chk("beq2_c3_pc_src", 32'(pc_src), 0);
        chk("beq2_c3_rf_we", 32'(rf_we), 0);
        next(1'b1);
        chk("beq2_instret", instret, 4);

        // ADD to x0: WB without a register write
        instr = I_ADD0;
        next(1'b1);
        next(1'b1);
        chk("add_c3_alu_a", 32'(alu_src_a), 0);
        chk("add_c3_alu_b", 32'(alu_src_b), 0);
        next(1'b1);
        chk("add_c4_rf_we", 32'(rf_we), 0);
        chk("add_c4_pc_we", 32'(pc_we), 1);
        chk("add_c4_pc_src", 32'(pc_src), 0);
        next(1'b1);
        chk("add_instret", instret, 5);

        // JAL x1
        instr = I_JAL;
        next(1'b1);
        next(1'b1);
        next(1'b1);
        chk("jal_c4_wb_sel", 32'(wb_sel), 2);
        chk("jal_c4_pc_src", 32'(pc_src), 1);
        chk("jal_c4_pc_we", 32'(pc_we), 1);
        chk("jal_c4_rf_we", 32'(rf_we), 1);
        chk("jal_c4_rf_w", 32'(rf_w), 1);
        next(1'b1);
        chk("jal_instret", instret, 6);

        // SW stalled in MEM, then reset mid-access
        instr = I_SW;
        next(1'b1);
        next(1'b1);
        next(1'b0);
        chk("sw_c4_mem_req", 32'(mem_req), 1);
        chk("sw_c4_mem_we", 32'(mem_we), 1);
        chk("sw_c4_addr_src", 32'(addr_src), 1);
        rst = 1'b1;
        #1;
        chk("sw_rst_mem_req", 32'(mem_req), 0);
        chk("sw_rst_mem_we", 32'(mem_we), 0);
        release_rst(1'b0);
        chk("sw_post_fetch_req", 32'(mem_req), 1);
        chk("sw_post_instret", instret, 0);
        chk("sw_post_halted", 32'(halted), 0);
        chk("sw_post_cause", 32'(halt_cause), 0);

        // ECALL halts from DECODE without retiring
        instr = I_ECALL;
        next(1'b1);
        chk("ecall_c2_ir_we", 32'(ir_we), 1);
        next(1'b1);
        next(1'b1);
        chk("ecall_halted", 32'(halted), 1);
        chk("ecall_cause", 32'(halt_cause), 1);
        chk("ecall_instret", instret, 0);
        chk("ecall_mem_req", 32'(mem_req), 0);
        next(1'b1);
        chk("ecall_stays_halted", 32'(halted), 1);
        chk("ecall_stays_ir_we", 32'(ir_we), 0);

        // ADDI then an illegal opcode
        rst = 1'b1;
        instr = I_ADDI;
        release_rst(1'b1);
        next(1'b1);
        next(1'b1);
        next(1'b1);
        next(1'b1);
        chk("ill_pre_instret", instret, 1);
        instr = I_ILL;
        next(1'b1);
        next(1'b1);
        chk("ill_halted", 32'(halted), 1);
        chk("ill_cause", 32'(halt_cause), 2);
        chk("ill_instret", instret, 1);
        chk("ill_pc_we", 32'(pc_we), 0);

        // Fetch timeout with MEM_TIMEOUT=4
        rst = 1'b1;
        release_rst(1'b0);
        chk("to_c1_mem_req", 32'(mem_req), 1);
        next(1'b0);
        next(1'b0);
        chk("to_c3_mem_req", 32'(mem_req), 1);
        chk("to_c3_halted", 32'(halted), 0);
        next(1'b0);
        chk("to_c4_mem_req", 32'(mem_req), 0);
        chk("to_c4_halted", 32'(halted), 0);
        next(1'b0);
        chk("to_c5_halted", 32'(halted), 1);
        chk("to_c5_cause", 32'(halt_cause), 3);
        chk("to_c5_instret", instret, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
